// File: rtl/xprod_arbiter.sv
// Round-robin front end sharing one 3-stage signed cross-product pipeline,
// computing (B-A)x(C-A) for NREQ clients and tagging each result with its requester ID.
module xprod_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 10,
    localparam int IDW = $clog2(NREQ),
    localparam int CW  = 2*W + 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_ax,
    input  logic [NREQ*W-1:0] req_ay,
    input  logic [NREQ*W-1:0] req_bx,
    input  logic [NREQ*W-1:0] req_by,
    input  logic [NREQ*W-1:0] req_cx,
    input  logic [NREQ*W-1:0] req_cy,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [CW-1:0]     rsp_cross,
    output logic              rsp_neg,
    output logic              rsp_zero
);
    localparam int PW = 2*W + 2;

    logic [IDW-1:0]       last_q, last_d;
    logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [IDW-1:0]       id1_q, id1_d, id2_q, id2_d, rsp_id_q, rsp_id_d;
    logic signed [W:0]    dx1_q, dx1_d, dy1_q, dy1_d, dx2_q, dx2_d, dy2_q, dy2_d;
    logic signed [PW-1:0] p1_q, p1_d, p2_q, p2_d;
    logic [CW-1:0]        rsp_cross_q, rsp_cross_d;
    logic                 rsp_neg_q, rsp_neg_d, rsp_zero_q, rsp_zero_d;

    logic                 stall_s, gnt_found_s, accept_s;
    logic [IDW-1:0]       gnt_idx_s;
    logic [NREQ-1:0]      req_ready_s;
    logic [W-1:0]         ax_s, ay_s, bx_s, by_s, cx_s, cy_s;
    logic signed [CW-1:0] cross_s;

    // Stall whenever a result sits at the output and the consumer refuses it.
    assign stall_s = v3_q & ~rsp_ready;

    // Round-robin search: walking k downward lets the requester nearest last+1 win.
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && (i == (int'(last_q) + k) % NREQ)) begin
                    gnt_found_s = 1'b1;
                    gnt_idx_s   = IDW'(i);
                end else begin
                    gnt_found_s = gnt_found_s;
                    gnt_idx_s   = gnt_idx_s;
                end
            end
        end
        if (gnt_found_s && !stall_s && !reset) begin
            req_ready_s = NREQ'(1'b1) << gnt_idx_s;
        end else begin
            req_ready_s = '0;
        end
    end

    assign req_ready = req_ready_s;
    assign accept_s  = |req_ready_s;

    // Operand mux for the granted requester.
    always_comb begin
        ax_s = '0;
        ay_s = '0;
        bx_s = '0;
        by_s = '0;
        cx_s = '0;
        cy_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            ax_s = (gnt_idx_s == IDW'(i)) ? req_ax[i*W +: W] : ax_s;
            ay_s = (gnt_idx_s == IDW'(i)) ? req_ay[i*W +: W] : ay_s;
            bx_s = (gnt_idx_s == IDW'(i)) ? req_bx[i*W +: W] : bx_s;
            by_s = (gnt_idx_s == IDW'(i)) ? req_by[i*W +: W] : by_s;
            cx_s = (gnt_idx_s == IDW'(i)) ? req_cx[i*W +: W] : cx_s;
            cy_s = (gnt_idx_s == IDW'(i)) ? req_cy[i*W +: W] : cy_s;
        end
    end

    // S3 combine: operands fit in PW bits, so one extra bit makes the difference exact.
    assign cross_s = $signed({p1_q[PW-1], p1_q}) - $signed({p2_q[PW-1], p2_q});

    // Next-state for all pipeline stages; everything holds while stalled.
    always_comb begin
        last_d      = last_q;
        v1_d        = v1_q;
        v2_d        = v2_q;
        v3_d        = v3_q;
        id1_d       = id1_q;
        dx1_d       = dx1_q;
        dy1_d       = dy1_q;
        dx2_d       = dx2_q;
        dy2_d       = dy2_q;
        id2_d       = id2_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        rsp_id_d    = rsp_id_q;
        rsp_cross_d = rsp_cross_q;
        rsp_neg_d   = rsp_neg_q;
        rsp_zero_d  = rsp_zero_q;
        if (!stall_s) begin
            v1_d = accept_s;
            v2_d = v1_q;
            v3_d = v2_q;
            if (accept_s) begin
                last_d = gnt_idx_s;
                id1_d  = gnt_idx_s;
                dx1_d  = $signed({1'b0, bx_s}) - $signed({1'b0, ax_s});
                dy1_d  = $signed({1'b0, cy_s}) - $signed({1'b0, ay_s});
                dx2_d  = $signed({1'b0, cx_s}) - $signed({1'b0, ax_s});
                dy2_d  = $signed({1'b0, by_s}) - $signed({1'b0, ay_s});
            end else begin
                last_d = last_q;
            end
            if (v1_q) begin
                id2_d = id1_q;
                p1_d  = $signed({{(W+1){dx1_q[W]}}, dx1_q}) * $signed({{(W+1){dy1_q[W]}}, dy1_q});
                p2_d  = $signed({{(W+1){dx2_q[W]}}, dx2_q}) * $signed({{(W+1){dy2_q[W]}}, dy2_q});
            end else begin
                id2_d = id2_q;
            end
            if (v2_q) begin
                rsp_id_d    = id2_q;
                rsp_cross_d = cross_s;
                rsp_neg_d   = cross_s[CW-1];
                rsp_zero_d  = ~|cross_s;
            end else begin
                rsp_id_d = rsp_id_q;
            end
        end else begin
            v1_d = v1_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q      <= IDW'(NREQ - 1);
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            id1_q       <= '0;
            dx1_q       <= '0;
            dy1_q       <= '0;
            dx2_q       <= '0;
            dy2_q       <= '0;
            id2_q       <= '0;
            p1_q        <= '0;
            p2_q        <= '0;
            rsp_id_q    <= '0;
            rsp_cross_q <= '0;
            rsp_neg_q   <= 1'b0;
            rsp_zero_q  <= 1'b0;
        end else begin
            last_q      <= last_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            v3_q        <= v3_d;
            id1_q       <= id1_d;
            dx1_q       <= dx1_d;
            dy1_q       <= dy1_d;
            dx2_q       <= dx2_d;
            dy2_q       <= dy2_d;
            id2_q       <= id2_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            rsp_id_q    <= rsp_id_d;
            rsp_cross_q <= rsp_cross_d;
            rsp_neg_q   <= rsp_neg_d;
            rsp_zero_q  <= rsp_zero_d;
        end
    end

    assign rsp_valid = v3_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_cross = rsp_cross_q;
    assign rsp_neg   = rsp_neg_q;
    assign rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_xprod_arbiter.sv
// Bench for xprod_arbiter: directed geometry cases plus randomized traffic checked
// against a cycle-level reference built from the arbitration and latency rules.
module tb_xprod_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 10;
    localparam int IDW  = 2;
    localparam int CW   = 2*W + 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid, req_ready;
    logic [NREQ*W-1:0] req_ax, req_ay, req_bx, req_by, req_cx, req_cy;
    logic              rsp_valid, rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [CW-1:0]     rsp_cross;
    logic              rsp_neg, rsp_zero;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: RR pointer plus a 3-deep delay line of expected results.
    int last_m;
    bit sv[3];
    int sid[3];
    int sx[3];
    int g_last;
    int gnt_log[$];

    xprod_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ax(req_ax), .req_ay(req_ay), .req_bx(req_bx),
        .req_by(req_by), .req_cx(req_cx), .req_cy(req_cy),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_cross(rsp_cross), .rsp_neg(rsp_neg), .rsp_zero(rsp_zero)
    );

    always #5 clk = ~clk;

    function automatic int get_op(logic [NREQ*W-1:0] bus, int i);
        return int'(bus[i*W +: W]);
    endfunction

    function automatic int model_cross(int i);
        int ax, ay, bx, by, cx, cy;
        ax = get_op(req_ax, i); ay = get_op(req_ay, i);
        bx = get_op(req_bx, i); by = get_op(req_by, i);
        cx = get_op(req_cx, i); cy = get_op(req_cy, i);
        return (bx - ax) * (cy - ay) - (cx - ax) * (by - ay);
    endfunction

    task automatic set_ops(int i, int ax, int ay, int bx, int by, int cx, int cy);
        req_ax[i*W +: W] = W'(ax); req_ay[i*W +: W] = W'(ay);
        req_bx[i*W +: W] = W'(bx); req_by[i*W +: W] = W'(by);
        req_cx[i*W +: W] = W'(cx); req_cy[i*W +: W] = W'(cy);
    endtask

    task automatic rand_ops(int i);
        if ($urandom_range(0, 7) == 0)
            set_ops(i, 1023 * $urandom_range(0, 1), 1023 * $urandom_range(0, 1),
                    1023 * $urandom_range(0, 1), 1023 * $urandom_range(0, 1),
                    1023 * $urandom_range(0, 1), 1023 * $urandom_range(0, 1));
        else
            set_ops(i, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023),
                    $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
    endtask

    task automatic model_reset();
        last_m = NREQ - 1;
        for (int s = 0; s < 3; s++) begin
            sv[s] = 1'b0; sid[s] = 0; sx[s] = 0;
        end
    endtask

    // One clock: check grant before the edge, advance the model, check response after it.
    task automatic cycle();
        int g, nx, got;
        bit stall_m;
        logic [NREQ-1:0] exp_rdy;
        @(negedge clk);
        stall_m = sv[2] && !rsp_ready;
        g = -1;
        if (!stall_m) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (g < 0 && req_valid[(last_m + k) % NREQ]) g = (last_m + k) % NREQ;
            end
        end
        exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
        n_tests++;
        if (req_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL req_ready: got %b expected %b at %0t", req_ready, exp_rdy, $time);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i] && req_valid[i]) gnt_log.push_back(i);
        end
        nx = (g >= 0) ? model_cross(g) : 0;
        @(posedge clk);
        if (!stall_m) begin
            sv[2] = sv[1]; sid[2] = sid[1]; sx[2] = sx[1];
            sv[1] = sv[0]; sid[1] = sid[0]; sx[1] = sx[0];
            sv[0] = (g >= 0); sid[0] = g; sx[0] = nx;
            if (g >= 0) last_m = g;
        end
        g_last = g;
        #1;
        n_tests++;
        if (rsp_valid !== sv[2]) begin
            n_fail++;
            $display("FAIL rsp_valid: got %b expected %b at %0t", rsp_valid, sv[2], $time);
        end else if (sv[2]) begin
            got = int'($signed(rsp_cross));
            n_tests++;
            if (rsp_id !== IDW'(sid[2]) || got != sx[2] || rsp_neg !== (sx[2] < 0) ||
                rsp_zero !== (sx[2] == 0)) begin
                n_fail++;
                $display("FAIL rsp_data: got id %0d cross %0d neg %b zero %b expected id %0d cross %0d",
                         rsp_id, got, rsp_neg, rsp_zero, sid[2], sx[2]);
            end
        end
        if (g >= 0) rand_ops(g);
    endtask

    task automatic apply_reset();
        req_valid = '0;
        rsp_ready = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        req_valid = '1;
        #3;
        n_tests++;
        if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_cross !== '0 ||
            rsp_neg !== 1'b0 || rsp_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: got rdy %b v %b id %0d x %0d n %b z %b expected all zero",
                     req_ready, rsp_valid, rsp_id, rsp_cross, rsp_neg, rsp_zero);
        end
        apply_reset();
    endtask

    task automatic send_dir(string name, int id, int ax, int ay, int bx, int by,
                            int cx, int cy, int exp_x);
        int n, got;
        set_ops(id, ax, ay, bx, by, cx, cy);
        req_valid = '0;
        req_valid[id] = 1'b1;
        cycle();
        req_valid[id] = 1'b0;
        n = 0;
        while (!rsp_valid && n < 6) begin
            cycle();
            n++;
        end
        n_tests++;
        if (n != 2 || !rsp_valid) begin
            n_fail++;
            $display("FAIL %s latency: got %0d extra cycles expected 2", name, n);
        end else begin
            got = int'($signed(rsp_cross));
            n_tests++;
            if (rsp_id !== IDW'(id) || got != exp_x || rsp_neg !== (exp_x < 0) ||
                rsp_zero !== (exp_x == 0)) begin
                n_fail++;
                $display("FAIL %s: got id %0d cross %0d neg %b zero %b expected id %0d cross %0d",
                         name, rsp_id, got, rsp_neg, rsp_zero, id, exp_x);
            end
        end
        cycle();
    endtask

    task automatic test_geometry();
        send_dir("ccw", 0, 0, 0, 4, 0, 0, 3, 12);
        send_dir("cw", 2, 0, 0, 0, 3, 4, 0, -12);
        send_dir("collinear", 1, 1, 1, 2, 2, 5, 5, 0);
        send_dir("max_pos", 3, 0, 0, 1023, 0, 0, 1023, 1046529);
        send_dir("max_neg", 0, 0, 0, 0, 1023, 1023, 0, -1046529);
        send_dir("max_corner", 2, 1023, 1023, 0, 1023, 1023, 0, 1046529);
    endtask

    task automatic check_log(string name, int exp_seq[$]);
        n_tests++;
        if (gnt_log.size() != exp_seq.size()) begin
            n_fail++;
            $display("FAIL %s length: got %0d expected %0d", name, gnt_log.size(), exp_seq.size());
        end else begin
            for (int k = 0; k < exp_seq.size(); k++) begin
                n_tests++;
                if (gnt_log[k] != exp_seq[k]) begin
                    n_fail++;
                    $display("FAIL %s[%0d]: got %0d expected %0d", name, k, gnt_log[k], exp_seq[k]);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i < NREQ; i++) rand_ops(i);
        req_valid = '1;
        gnt_log.delete();
        repeat (8) cycle();
        check_log("rr_all", '{0, 1, 2, 3, 0, 1, 2, 3});
        repeat (2) cycle();
        req_valid[1] = 1'b0;
        gnt_log.delete();
        repeat (4) cycle();
        check_log("rr_drop1", '{2, 3, 0, 2});
        req_valid = '0;
        repeat (4) cycle();
    endtask

    task automatic test_backpressure();
        logic [CW-1:0]  hold_x;
        logic [IDW-1:0] hold_id;
        int cnt;
        req_valid = '0;
        req_valid[0] = 1'b1;
        repeat (3) cycle();
        req_valid[0] = 1'b0;
        req_valid[3] = 1'b1;
        rsp_ready = 1'b0;
        hold_x = rsp_cross;
        hold_id = rsp_id;
        for (int c = 0; c < 5; c++) begin
            cycle();
            n_tests++;
            if (rsp_valid !== 1'b1 || rsp_cross !== hold_x || rsp_id !== hold_id || req_ready !== '0) begin
                n_fail++;
                $display("FAIL stall_hold: got v %b x %0d id %0d rdy %b expected v 1 x %0d id %0d rdy 0",
                         rsp_valid, rsp_cross, rsp_id, req_ready, hold_x, hold_id);
            end
        end
        rsp_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 3; c++) begin
            if (rsp_valid && rsp_id == 2'd0) cnt++;
            cycle();
            if (c == 0) req_valid[3] = 1'b0;
        end
        n_tests++;
        if (cnt != 3) begin
            n_fail++;
            $display("FAIL release_burst: got %0d consecutive results expected 3", cnt);
        end
        repeat (4) cycle();
    endtask

    task automatic test_reset_midflight();
        req_valid = '0;
        req_valid[1] = 1'b1;
        repeat (2) cycle();
        req_valid[1] = 1'b0;
        cycle();
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: got rsp_valid %b expected 0", rsp_valid);
        end
        apply_reset();
        req_valid = '1;
        gnt_log.delete();
        cycle();
        check_log("post_reset_grant", '{0});
        req_valid = '0;
        repeat (5) cycle();
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < NREQ; i++) rand_ops(i);
        g_last = -1;
        for (int c = 0; c < 600; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i]) req_valid[i] = ($urandom_range(0, 2) == 0);
                else if (i == g_last) req_valid[i] = $urandom_range(0, 1);
                else if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
            end
            cycle();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (5) cycle();
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        req_ax = '0; req_ay = '0; req_bx = '0; req_by = '0; req_cx = '0; req_cy = '0;
        model_reset();
        g_last = -1;
        test_reset();
        test_geometry();
        test_round_robin();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/xprod_arbiter.md
# xprod_arbiter

Shared cross-product engine with a round-robin front end. Up to NREQ geometry clients, such as geofence or polygon-sort controllers, submit point triples (A, B, C). The block computes the signed 2-D cross product (B−A)×(C−A) in a 3-stage pipeline and returns the result tagged with the requester ID. One requester is accepted per cycle. The block sits between the geometry FSMs and the single multiplier pair so that the multipliers are not duplicated per client.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 10, unsigned coordinate width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  NREQ  request pending, bit i = requester i
- req_ready  out  NREQ  one-hot grant; transfer on req_valid[i] & req_ready[i]
- req_ax, req_ay, req_bx, req_by, req_cx, req_cy  in  NREQ*W each  operands; requester i occupies bits [i*W +: W]
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  clog2(NREQ)  requester index of the result
- rsp_cross  out  2W+3  signed (bx−ax)(cy−ay) − (cx−ax)(by−ay)
- rsp_neg  out  1  rsp_cross < 0 (clockwise)
- rsp_zero  out  1  rsp_cross == 0 (collinear)

## Operation
- **Arbitration.** Round-robin with pointer `last` (reset value NREQ−1, so requester 0 wins first). The grant goes to the first i with req_valid[i]=1, searching cyclically from last+1. `last` updates only on an accepted transfer.
- **Grant conditions.** req_ready is combinational and one-hot. It is all-zero when no request is pending or the pipeline is stalled. A requester holds req_valid and its operands stable until granted. Dropping valid before the grant is legal; the request is then simply not taken.
- **S1 (capture).** Register the ID and the four differences dx1=bx−ax, dy1=cy−ay, dx2=cx−ax, dy2=by−ay. Each difference is signed W+1 bits with zero-extended operands and never overflows.
- **S2 (multiply).** p1=dx1*dy1 and p2=dx2*dy2, signed 2W+2 bits each, registered.
- **S3 (combine).** cross=p1−p2, signed 2W+3 bits, with no saturation. rsp_neg is the MSB. rsp_zero is the NOR of all bits. The result is registered into the output stage.
- **Pipeline control.** Per-stage valid bits v1, v2, v3, where v3 drives rsp_valid. The pipeline has two states:
  - RUN: the stages advance every cycle.
  - STALL: entered when v3=1 and rsp_ready=0. All stage registers hold and req_ready=0. Leaves on the first cycle with rsp_ready=1.
- **Ordering.** Results leave in grant order and none are dropped or duplicated.

## Timing
- **Reset values.** req_ready=0 while reset is asserted; after reset, req_ready follows the grant logic. rsp_valid=0, rsp_id=0, rsp_cross=0, rsp_neg=0, rsp_zero=0. v1=v2=v3=0, last=NREQ−1.
- **Latency.** A request accepted at edge t produces rsp_valid=1 after edge t+2, visible in cycle t+3.
- **Throughput.** One result per cycle while rsp_ready=1. The pipeline may run full with no bubbles.
- **Response handshake.** rsp_valid/rsp_id/rsp_cross stay stable while rsp_valid=1 and rsp_ready=0. rsp_ready is ignored while rsp_valid=0.
- **Simultaneous release and request.** If a stall releases and a request is pending in the same cycle, the request is granted in that cycle.
- **Reset mid-operation.** All in-flight results are discarded. No response is emitted for them and `last` returns to NREQ−1.
- **Single requester.** A lone requester with continuous valid is granted every cycle while the pipeline is not stalled.

## Test plan
- **Counter-clockwise triple.** Requester 0 sends A=(0,0), B=(4,0), C=(0,3) → rsp_valid 3 cycles later with rsp_id=0, rsp_cross=12, rsp_neg=0, rsp_zero=0.
- **Sign and collinear cases.**
  - Requester 2 sends A=(0,0), B=(0,3), C=(4,0) → rsp_cross=−12, rsp_neg=1.
  - A=(1,1), B=(2,2), C=(5,5) → rsp_cross=0, rsp_zero=1.
- **Width extremes (W=10).**
  - A=(0,0), B=(1023,0), C=(0,1023) → +1046529.
  - A=(0,0), B=(0,1023), C=(1023,0) → −1046529.
  - A=(1023,1023), B=(0,1023), C=(1023,0) → +1046529.
  - None of these may wrap.
- **Round-robin fairness.** All four requesters hold valid continuously for 8 cycles after reset → grants in order 0,1,2,3,0,1,2,3 and rsp_id in the same order. Then requester 1 drops valid → grant sequence 2,3,0,2,…
- **Backpressure.** Feed 3 back-to-back requests, then hold rsp_ready=0 for 5 cycles → req_ready=0 and outputs frozen throughout the stall. After release, all 3 results appear on consecutive cycles, in order, with no loss.
- **Reset mid-flight.** Pulse reset asynchronously with 2 results in flight → rsp_valid falls immediately and neither result appears afterward. The first post-reset grant with all requesters valid goes to requester 0.
